spi_reg_ctrl: RTL and testbench

Byte-level command controller that sits on top of the SPI byte interface (`spi_byte_if`) and turns the slave byte stream into a small register file. The first byte of each SS frame is a command carrying the direction and a 7-bit address. The following bytes are either written into registers or read back through the tx byte. Register contents drive the FPGA-side control outputs, such as LEDs; the SPI master gets read-back.

---
 rtl/spi_reg_ctrl_pkg.sv | 20 ++
 rtl/spi_reg_ctrl_if.sv | 26 ++
 rtl/spi_reg_ctrl_ss_sync.sv | 39 +++
 rtl/spi_reg_ctrl.sv | 146 ++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI command/register controller.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD
    } state_t;

    localparam int         CMD_RD_BIT = 7;
    localparam int         ADDR_W     = 7;
    localparam logic [7:0] IDLE_TX    = 8'h55;
    localparam logic [7:0] OOR_TX     = 8'hFF;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + 7'd1;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-stream and register-file bundle between the SPI byte layer and the controller.
interface spi_reg_ctrl_if #(
    parameter int NREGS = 8
);
    import spi_reg_pkg::*;

    logic                  SS;
    logic                  rxValid;
    logic [7:0]            rx;
    logic [7:0]            tx;
    logic [8*NREGS-1:0]    regs;
    logic                  wrValid;
    logic [ADDR_W-1:0]     wrAddr;
    logic [7:0]            wrData;

    modport master (
        output SS, rxValid, rx,
        input  tx, regs, wrValid, wrAddr, wrData
    );

    modport slave (
        input  SS, rxValid, rx,
        output tx, regs, wrValid, wrAddr, wrData
    );

endinterface

// File: rtl/spi_reg_ctrl_ss_sync.sv
// Two-flop SS synchronizer with edge pulses; a fall only counts once SS has been seen high
// after reset, so a frame that straddles reset stays ignored.
module spi_ss_sync (
    input  logic clk,
    input  logic rst,
    input  logic ss_i,
    output logic fall_o,
    output logic rise_o
);

    logic       s1_q, s2_q, s3_q;
    logic [1:0] fill_q;
    logic       armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            s3_q    <= 1'b1;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            s1_q <= ss_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            // s2 holds a real pin sample only once the preset values have drained out
            if (fill_q == 2'd2 && s2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign fall_o = armed_q & s3_q & ~s2_q;
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command decoder and register file on top of the SPI byte stream.
// Define SPI_REG_CTRL_AUTOINC_EN to advance the address after every data byte (burst access).
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         NREGS   = 8,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input logic           sysClk,
    input logic           usrReset,
    spi_reg_ctrl_if.slave bus
);

    logic ss_fall, ss_rise;

    spi_ss_sync u_ss_sync (
        .clk    (sysClk),
        .rst    (usrReset),
        .ss_i   (bus.SS),
        .fall_o (ss_fall),
        .rise_o (ss_rise)
    );

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en, wr_en, wr_hit;
    logic [7:0]        rd_byte;
    logic [7:0]        tx_q, tx_d;
    logic              wrValid_q, wrValid_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [7:0]        wrData_q, wrData_d;
    logic [7:0]        regs_q [NREGS];
    logic [7:0]        regs_d [NREGS];

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_CTRL_AUTOINC_EN
        return addr_inc(a);
`else
        return a;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        rd_addr = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (bus.rxValid) begin
                    addr_d = bus.rx[ADDR_W-1:0];
                    if (bus.rx[CMD_RD_BIT]) begin
                        state_d = ST_RD;
                        rd_en   = 1'b1;
                        rd_addr = bus.rx[ADDR_W-1:0];
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (bus.rxValid) begin
                    wr_en  = 1'b1;
                    addr_d = step_addr(addr_q);
                end
            end
            ST_RD: begin
                if (bus.rxValid) begin
                    rd_en   = 1'b1;
                    addr_d  = step_addr(addr_q);
                    rd_addr = step_addr(addr_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A byte landing with the SS rise is still processed above before the frame closes
        if (ss_rise) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        regs_d  = regs_q;
        wr_hit  = 1'b0;
        rd_byte = OOR_TX;
        for (int n = 0; n < NREGS; n++) begin
            if (wr_en && addr_q == ADDR_W'(n)) begin
                regs_d[n] = bus.rx;
                wr_hit    = 1'b1;
            end
            if (rd_addr == ADDR_W'(n)) begin
                rd_byte = regs_q[n];
            end
        end

        wrValid_d = wr_hit;
        wrAddr_d  = wr_hit ? addr_q : wrAddr_q;
        wrData_d  = wr_hit ? bus.rx : wrData_q;

        tx_d = tx_q;
        if (state_d != ST_RD) begin
            tx_d = IDLE_TX;
        end else if (rd_en) begin
            tx_d = rd_byte;
        end
    end

    always_ff @(posedge sysClk) begin
        if (usrReset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            tx_q      <= IDLE_TX;
            wrValid_q <= 1'b0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
            for (int n = 0; n < NREGS; n++) begin
                regs_q[n] <= RST_VAL;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            wrValid_q <= wrValid_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
            regs_q    <= regs_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.wrValid = wrValid_q;
    assign bus.wrAddr  = wrAddr_q;
    assign bus.wrData  = wrData_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_regs
        assign bus.regs[8*g +: 8] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: an 8-register and a 128-register instance side by side.
module tb_spi_reg_ctrl;
    import spi_reg_pkg::*;

`ifdef SPI_REG_CTRL_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    localparam logic [7:0] RV8   = 8'h00;
    localparam logic [7:0] RV128 = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_reg_ctrl_if #(.NREGS(8))   b8 ();
    spi_reg_ctrl_if #(.NREGS(128)) b128 ();

    spi_reg_ctrl #(.NREGS(8), .RST_VAL(RV8)) u8 (
        .sysClk   (clk),
        .usrReset (rst),
        .bus      (b8.slave)
    );

    spi_reg_ctrl #(.NREGS(128), .RST_VAL(RV128)) u128 (
        .sysClk   (clk),
        .usrReset (rst),
        .bus      (b128.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  txq8 [$];
    logic [7:0]  txq128 [$];
    logic [14:0] wrq8 [$];
    logic [14:0] wrq128 [$];
    logic [7:0]  m8 [8];
    logic [7:0]  m128 [128];
    logic        rxv8 = 1'b0;
    logic        rxv128 = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        rxv8   <= b8.rxValid;
        rxv128 <= b128.rxValid;
    end

    // Monitor: tx after every accepted byte, and every wrValid pulse
    always @(negedge clk) begin
        logic [8:0]  etx;
        logic [15:0] ewr;
        if (rxv8) begin
            etx = (txq8.size() != 0) ? {1'b0, txq8.pop_front()} : 9'h100;
            check("tx8", {23'd0, 1'b0, b8.tx}, {23'd0, etx});
        end
        if (rxv128) begin
            etx = (txq128.size() != 0) ? {1'b0, txq128.pop_front()} : 9'h100;
            check("tx128", {23'd0, 1'b0, b128.tx}, {23'd0, etx});
        end
        if (b8.wrValid !== 1'b0) begin
            ewr = (wrq8.size() != 0) ? {1'b0, wrq8.pop_front()} : 16'h8000;
            check("wr8", {16'd0, 1'b0, b8.wrAddr, b8.wrData}, {16'd0, ewr});
        end
        if (b128.wrValid !== 1'b0) begin
            ewr = (wrq128.size() != 0) ? {1'b0, wrq128.pop_front()} : 16'h8000;
            check("wr128", {16'd0, 1'b0, b128.wrAddr, b128.wrData}, {16'd0, ewr});
        end
    end

    function automatic logic [7:0] rdval(input int d, input logic [6:0] a);
        if (d == 0) return (a < 7'd8) ? m8[a[2:0]] : OOR_TX;
        return m128[a];
    endfunction

    task automatic push_tx(input int d, input logic [7:0] v);
        if (d == 0) txq8.push_back(v);
        else        txq128.push_back(v);
    endtask

    task automatic push_wr(input int d, input logic [6:0] a, input logic [7:0] v);
        if (d == 0) begin
            wrq8.push_back({a, v});
            m8[a[2:0]] = v;
        end else begin
            wrq128.push_back({a, v});
            m128[a] = v;
        end
    endtask

    task automatic set_ss(input int d, input logic v);
        if (d == 0) b8.SS = v;
        else        b128.SS = v;
    endtask

    task automatic set_rx(input int d, input logic vld, input logic [7:0] b);
        if (d == 0) begin
            b8.rxValid = vld;
            b8.rx      = b;
        end else begin
            b128.rxValid = vld;
            b128.rx      = b;
        end
    endtask

    task automatic pulse_rx(input int d, input logic [7:0] b);
        @(posedge clk); #1;
        set_rx(d, 1'b1, b);
        @(posedge clk); #1;
        set_rx(d, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_regs(input int d);
        if (d == 0) begin
            for (int n = 0; n < 8; n++)
                check($sformatf("reg8[%0d]", n), {24'd0, b8.regs[8*n +: 8]}, {24'd0, m8[n]});
        end else begin
            for (int n = 0; n < 128; n++)
                check($sformatf("reg128[%0d]", n), {24'd0, b128.regs[8*n +: 8]}, {24'd0, m128[n]});
        end
    endtask

    task automatic do_frame(input int d, input logic [7:0] cmd, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] bytes [3];
        logic [6:0] addr;
        int         nr;
        bytes = '{b0, b1, b2};
        addr  = cmd[6:0];
        nr    = (d == 0) ? 8 : 128;
        set_ss(d, 1'b0);
        repeat (5) @(posedge clk);
        push_tx(d, cmd[7] ? rdval(d, addr) : IDLE_TX);
        pulse_rx(d, cmd);
        for (int i = 0; i < n; i++) begin
            if (!cmd[7]) begin
                if (int'(addr) < nr) push_wr(d, addr, bytes[i]);
                push_tx(d, IDLE_TX);
                pulse_rx(d, bytes[i]);
                if (AI) addr = addr + 7'd1;
            end else begin
                if (AI) addr = addr + 7'd1;
                push_tx(d, rdval(d, addr));
                pulse_rx(d, bytes[i]);
            end
        end
        set_ss(d, 1'b1);
        repeat (5) @(posedge clk);
        check_regs(d);
    endtask

    task automatic model_reset();
        for (int n = 0; n < 8; n++)   m8[n]   = RV8;
        for (int n = 0; n < 128; n++) m128[n] = RV128;
    endtask

    initial begin
        b8.SS = 1'b1;   b8.rxValid = 1'b0;   b8.rx = 8'h00;
        b128.SS = 1'b1; b128.rxValid = 1'b0; b128.rx = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_tx8", {24'd0, b8.tx}, {24'd0, IDLE_TX});
        check("rst_tx128", {24'd0, b128.tx}, {24'd0, IDLE_TX});
        check("rst_wrvalid8", {31'd0, b8.wrValid}, 32'd0);
        check("rst_wraddr8", {25'd0, b8.wrAddr}, 32'd0);
        check("rst_wrdata8", {24'd0, b8.wrData}, 32'd0);
        check_regs(0);
        check_regs(1);

        // Byte outside any frame is ignored
        push_tx(0, IDLE_TX);
        pulse_rx(0, 8'h03);
        check_regs(0);

        do_frame(0, 8'h02, 2, 8'hAA, 8'hBB, 8'h00);
        do_frame(0, 8'h82, 2, 8'h00, 8'h00, 8'h00);
        do_frame(0, 8'h07, 2, 8'h11, 8'h22, 8'h00);
        do_frame(0, 8'h88, 1, 8'h00, 8'h00, 8'h00);
        do_frame(0, 8'h87, 1, 8'h00, 8'h00, 8'h00);
        do_frame(1, 8'h7F, 2, 8'h01, 8'h02, 8'h00);
        do_frame(1, 8'hFF, 2, 8'h00, 8'h00, 8'h00);
        do_frame(0, 8'h01, 2, 8'h05, 8'h06, 8'h00);

        // Command-only frame, then a normal frame
        do_frame(0, 8'h05, 0, 8'h00, 8'h00, 8'h00);
        do_frame(0, 8'h05, 1, 8'h77, 8'h00, 8'h00);

        // Data byte coincident with the SS rise detect still commits
        set_ss(0, 1'b0);
        repeat (5) @(posedge clk);
        push_tx(0, IDLE_TX);
        pulse_rx(0, 8'h06);
        @(posedge clk); #1;
        set_ss(0, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        push_wr(0, 7'h06, 8'h5A);
        push_tx(0, IDLE_TX);
        set_rx(0, 1'b1, 8'h5A);
        @(posedge clk); #1;
        set_rx(0, 1'b0, 8'h00);
        repeat (4) @(posedge clk);
        push_tx(0, IDLE_TX);
        pulse_rx(0, 8'h33);
        check_regs(0);

        // Reset in the middle of a write frame, SS held low across it
        set_ss(0, 1'b0);
        repeat (5) @(posedge clk);
        push_tx(0, IDLE_TX);
        pulse_rx(0, 8'h01);
        push_wr(0, 7'h01, 8'h99);
        push_tx(0, IDLE_TX);
        pulse_rx(0, 8'h99);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("midrst_tx8", {24'd0, b8.tx}, {24'd0, IDLE_TX});
        check("midrst_wraddr8", {25'd0, b8.wrAddr}, 32'd0);
        check("midrst_wrdata8", {24'd0, b8.wrData}, 32'd0);
        check_regs(0);
        check_regs(1);
        push_tx(0, IDLE_TX);
        pulse_rx(0, 8'h44);
        push_tx(0, IDLE_TX);
        pulse_rx(0, 8'h45);
        set_ss(0, 1'b1);
        repeat (5) @(posedge clk);
        check_regs(0);
        do_frame(0, 8'h03, 1, 8'h12, 8'h00, 8'h00);
        do_frame(0, 8'h83, 0, 8'h00, 8'h00, 8'h00);

        repeat (5) @(posedge clk);
        check("txq8_left", txq8.size(), 32'd0);
        check("txq128_left", txq128.size(), 32'd0);
        check("wrq8_left", wrq8.size(), 32'd0);
        check("wrq128_left", wrq128.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
